// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Used by seq_divider (optional signed mode via DIV_SIGNED_EN) and div_step.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

  // Quotient reported for a zero divisor: all ones, sliced to the operand width.
  localparam logic [MAX_WIDTH-1:0] DIV_BY_ZERO_Q = {MAX_WIDTH{1'b1}};

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// master drives operands and out_ready; slave is the divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic             busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, busy
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, shift in the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] dvd_nxt
);

  logic [WIDTH:0] shift_s;
  logic           fits_s;

  // Shifted remainder is one bit wider so the compare cannot overflow.
  always_comb begin
    shift_s = {rem, dvd[WIDTH-1]};
    fits_s  = (shift_s >= {1'b0, dsr});
    if (fits_s) begin
      rem_nxt = WIDTH'(shift_s - {1'b0, dsr});
    end else begin
      rem_nxt = shift_s[WIDTH-1:0];
    end
    dvd_nxt = {dvd[WIDTH-2:0], fits_s};
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define DIV_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state_r;
  state_t           state_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] rem_nxt_s;
  logic [WIDTH-1:0] dvd_nxt_s;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             dbz_r;
  logic             accept_s;
  logic             last_s;
  logic             zero_dsr_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;

  assign accept_s   = bus.in_valid && (state_r == IDLE);
  assign zero_dsr_s = (bus.divisor == {WIDTH{1'b0}});
  assign last_s     = (cnt_r == CW'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_r),
    .dvd     (dvd_r),
    .dsr     (dsr_r),
    .rem_nxt (rem_nxt_s),
    .dvd_nxt (dvd_nxt_s)
  );

`ifdef DIV_SIGNED_EN
  logic neg_q_r;
  logic neg_r_r;

  // Magnitudes on accept, sign restore on the last iteration. MIN maps to itself,
  // which is also its correct unsigned magnitude, so MIN/-1 needs no special case.
  always_comb begin
    if (bus.dividend[WIDTH-1]) begin
      a_mag_s = {WIDTH{1'b0}} - bus.dividend;
    end else begin
      a_mag_s = bus.dividend;
    end
    if (bus.divisor[WIDTH-1]) begin
      b_mag_s = {WIDTH{1'b0}} - bus.divisor;
    end else begin
      b_mag_s = bus.divisor;
    end
    if (neg_q_r) begin
      q_fix_s = {WIDTH{1'b0}} - dvd_nxt_s;
    end else begin
      q_fix_s = dvd_nxt_s;
    end
    if (neg_r_r) begin
      r_fix_s = {WIDTH{1'b0}} - rem_nxt_s;
    end else begin
      r_fix_s = rem_nxt_s;
    end
  end

  // Sign flags captured with the operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (accept_s) begin
      neg_q_r <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      neg_r_r <= bus.dividend[WIDTH-1];
    end
  end
`else
  assign a_mag_s = bus.dividend;
  assign b_mag_s = bus.divisor;
  assign q_fix_s = dvd_nxt_s;
  assign r_fix_s = rem_nxt_s;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          if (zero_dsr_s) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CW{1'b0}};
      rem_r       <= {WIDTH{1'b0}};
      dvd_r       <= {WIDTH{1'b0}};
      dsr_r       <= {WIDTH{1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      dbz_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cnt_r <= {CW{1'b0}};
            rem_r <= {WIDTH{1'b0}};
            dvd_r <= a_mag_s;
            dsr_r <= b_mag_s;
            if (zero_dsr_s) begin
              quotient_r  <= DIV_BY_ZERO_Q[WIDTH-1:0];
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_r <= rem_nxt_s;
          dvd_r <= dvd_nxt_s;
          cnt_r <= cnt_r + CW'(1);
          if (last_s) begin
            quotient_r  <= q_fix_s;
            remainder_r <= r_fix_s;
            dbz_r       <= 1'b0;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.in_ready    = (state_r == IDLE);
  assign bus.out_valid   = (state_r == DONE);
  assign bus.busy        = (state_r == CALC);
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule
